// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage with a prefetch queue on a Wishbone classic master port.
// Fetches sequentially ahead of decode; redirects flush the queue and drop in-flight responses.
module stage_if_prefetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] br_j_addr_i,
   input  logic [31:0] exception_addr_i,
   input  logic [1:0]  sel_addr_i,
   input  logic        stall_i,
   output logic        valid_o,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        fetch_err_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic [31:0] wbm_addr_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_dat_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_e;

   state_e        state_q;
   logic          cyc_q;
   logic          halt_q;
   logic [31:0]   addr_q;
   logic [31:0]   fpc_q;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          valid_q;
   logic [31:0]   insn_q;
   logic [31:0]   pc_q;
   logic          err_q;
   logic [31:0]   last_pc_q;

   logic [31:0]   mem_insn [FIFO_DEPTH];
   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic          mem_err  [FIFO_DEPTH];

   logic          redirect, resp, push, pop, issue;
   logic [31:0]   target, new_insn;
   logic [PW-1:0] rd_ptr_n, wr_ptr_n;
   logic [CW-1:0] count_n;
   logic          head_valid_n, head_err_n;
   logic [31:0]   head_insn_n, head_pc_n;

   // Queue bookkeeping; a redirect outranks both consume and push
   always_comb begin
      redirect = (sel_addr_i == 2'b01) || (sel_addr_i == 2'b10);
      target   = ((sel_addr_i == 2'b10) ? exception_addr_i : br_j_addr_i) & ~32'h3;
      resp     = wbm_ack_i | wbm_err_i;
      push     = (state_q == S_REQ) && resp && !redirect;
      pop      = valid_q && !stall_i && !redirect;
      new_insn = wbm_err_i ? NOP_INSN : wbm_dat_i;
      rd_ptr_n = redirect ? '0 : rd_ptr_q + PW'(pop);
      wr_ptr_n = redirect ? '0 : wr_ptr_q + PW'(push);
      count_n  = redirect ? '0 : count_q + CW'(push) - CW'(pop);
      issue    = (state_q == S_IDLE) && (count_q < CW'(FIFO_DEPTH)) && !halt_q && !redirect;
   end

   // Next head: a push into an (effectively) empty queue bypasses storage
   always_comb begin
      head_valid_n = 1'b0;
      head_insn_n  = NOP_INSN;
      head_err_n   = 1'b0;
      head_pc_n    = pop ? pc_q : last_pc_q;
      if (!redirect && (count_n != '0)) begin
         head_valid_n = 1'b1;
         if (push && (count_q == CW'(pop))) begin
            head_insn_n = new_insn;
            head_pc_n   = addr_q;
            head_err_n  = wbm_err_i;
         end else begin
            head_insn_n = mem_insn[rd_ptr_n];
            head_pc_n   = mem_pc[rd_ptr_n];
            head_err_n  = mem_err[rd_ptr_n];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_insn[wr_ptr_q] <= new_insn;
         mem_pc[wr_ptr_q]   <= addr_q;
         mem_err[wr_ptr_q]  <= wbm_err_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cyc_q     <= 1'b0;
         halt_q    <= 1'b0;
         addr_q    <= RESET_ADDR & ~32'h3;
         fpc_q     <= RESET_ADDR;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         insn_q    <= NOP_INSN;
         pc_q      <= RESET_ADDR;
         err_q     <= 1'b0;
         last_pc_q <= RESET_ADDR;
      end else begin
         rd_ptr_q  <= rd_ptr_n;
         wr_ptr_q  <= wr_ptr_n;
         count_q   <= count_n;
         valid_q   <= head_valid_n;
         insn_q    <= head_insn_n;
         pc_q      <= head_pc_n;
         err_q     <= head_err_n;
         if (pop) last_pc_q <= pc_q;

         if (redirect) begin
            fpc_q  <= target;
            halt_q <= 1'b0;
         end else if (push) begin
            if (wbm_err_i) halt_q <= 1'b1;
            else           fpc_q  <= fpc_q + 32'd4;
         end

         // DISCARD keeps the bus cycle alive on the old address until the slave answers
         case (state_q)
            S_IDLE: if (issue) begin
               state_q <= S_REQ;
               cyc_q   <= 1'b1;
               addr_q  <= fpc_q & ~32'h3;
            end
            S_REQ: if (resp) begin
               state_q <= S_IDLE;
               cyc_q   <= 1'b0;
            end else if (redirect) begin
               state_q <= S_DISCARD;
            end
            S_DISCARD: if (resp) begin
               state_q <= S_IDLE;
               cyc_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               cyc_q   <= 1'b0;
            end
         endcase
      end
   end

   assign valid_o       = valid_q;
   assign instruction_o = insn_q;
   assign pc_o          = pc_q;
   assign fetch_err_o   = err_q;
   assign wbm_cyc_o     = cyc_q;
   assign wbm_stb_o     = cyc_q;
   assign wbm_addr_o    = addr_q;
   assign wbm_sel_o     = 4'hF;
   assign wbm_we_o      = 1'b0;
   assign wbm_dat_o     = 32'h0;

endmodule
